pid_mc: RTL and testbench
=========================

Name: pid_mc

Overview:
- Time-multiplexed, N-channel incremental PID controller. Next generation of the single-channel PI loop.
- One ADC-complete event samples all channel inputs. The block runs them in sequence through one shared datapath, then updates every channel output at once.
- Adds a derivative term, runtime gains, fixed-point gain scaling, symmetric limits, per-channel enable and overrun detection.
- Sits between the ADC front-end and the PWM/DAC setpoint logic.

Parameters:
- N_CH, 2, number of control channels (1..8).
- PARAMETER_BIT_WIDTH, 26, signed width of error, gain, accumulator and output (W).
- INPUT_BIT_WIDTH, 12, unsigned ADC sample width per channel.
- FRAC_BITS, 0, arithmetic right shift applied to the summed increment (gain fraction bits).
- MAXIMUM_OUT, 1000, upper output clamp.
- MINIMUM_OUT, 0, lower output clamp.
- MAXIMUM_ADD, 100, upper increment clamp.
- MINIMUM_ADD, -100, lower increment clamp.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- adc_complete  in  1  ADC conversion done, asynchronous level
- sample  in  N_CH*INPUT_BIT_WIDTH  packed samples, channel 0 in the LSBs
- target  in  N_CH*W  packed signed setpoints
- kp, ki, kd  in  W each  signed runtime gains, shared by all channels
- ch_enable  in  N_CH  per-channel run enable
- pi_out  out  N_CH*W  packed signed outputs
- out_valid  out  1  one-cycle pulse when pi_out updates
- busy  out  1  high from LATCH through DONE
- overrun  out  1  one-cycle pulse when an ADC edge arrives while busy

Behaviour:
- Reset (asynchronous, active-low) clears everything to 0: pi_out, out_valid, busy, overrun, all e0/e1/e2 history, all accumulators and the FSM (to IDLE). Reset mid-computation abandons the pass; no partial output update occurs.
- adc_complete passes through a two-flop synchroniser. adc_read_flag = dly1 & ~dly2 (rising edge).
- FSM states: IDLE, LATCH, ERR, DIFF, MP, MI, MD, SUM, LIMA, ACC, LIMO, DONE.
  - IDLE: go to LATCH when adc_read_flag is high.
  - LATCH: snapshot sample, target, kp, ki, kd and ch_enable into registers; ch=0; go to ERR.
  - ERR: e0 = target[ch] - zero-extended sample[ch] (W-bit signed).
  - DIFF: d1 = e0 - e1[ch]; d2 = e0 - 2*e1[ch] + e2[ch].
  - MP: pp = kp*d1. MI: pi = ki*e0. MD: pd = kd*d2. One shared signed W x W multiplier, full 2W result.
  - SUM: s = (pp + pi + pd) >>> FRAC_BITS at 2W+2 bits, then saturated to W bits.
  - LIMA: clamp s to [MINIMUM_ADD, MAXIMUM_ADD].
  - ACC: acc[ch] += s at W+1 bits.
  - LIMO: clamp acc[ch] to [MINIMUM_OUT, MAXIMUM_OUT]; shift history e2=e1, e1=e0. If ch < N_CH-1: ch++ and go to ERR; else go to DONE.
  - DONE: all pi_out slices take acc; out_valid=1 for one cycle; go to IDLE.
- Disabled channel (snapshot ch_enable=0): ERR..LIMO still take their cycles, but acc and history are unchanged.
- Latency: out_valid asserts exactly 9*N_CH+3 clocks after the cycle in which adc_read_flag is high.
- An adc_read_flag while busy: pulse overrun for one cycle; the event is dropped, not queued.
- An adc_read_flag in the same cycle as DONE counts as busy, so overrun pulses.
- Gain or target changes during a pass have no effect until the next LATCH.

Decomposition:
- Package pid_mc_pkg holds:
  - the state enum;
  - the sat_w() and clamp() functions;
  - the DEFAULT_* limit constants.
- One sub-module, pid_mc_mac: the shared signed multiplier plus the three-term adder and shift/saturate stage. It has a registered product so that MP, MI and MD each take one cycle.

Test Plan:
All scenarios use N_CH=2, W=26, FRAC_BITS=0, kp=10, ki=1, kd=0, ch_enable=2'b11.
1. First step: ch0 target 500, sample 400; ch1 target 0, sample 0. One edge -> after 21 cycles out_valid pulses; ch0=100 (1100 clamped to MAXIMUM_ADD); ch1=0.
2. Steady error: repeat the same inputs -> du=100; ch0=200.
3. Error reversal: ch0 sample 550 (e0=-50, e1=100) -> du=-1550 clamped to -100; ch0=100.
4. Saturation and disable:
   - Ten more edges at e=+100 -> ch0 holds at 1000 and never exceeds it.
   - With ch_enable[1]=0, ch1 stays 0 whatever its error.
5. Overrun, fractional gain and reset:
   - Second adc_complete edge 5 cycles after the first -> overrun pulses once; only one out_valid occurs.
   - FRAC_BITS=4, kp=0, ki=16, kd=32, e=+3 from rest -> du=9 (3+6).
   - rst_n low during MD -> all outputs 0; the next edge behaves as a first sample.

Source files
------------

// File: rtl/pid_mc_pkg.sv
// Shared types and helpers for the multi-channel incremental PID controller.
// Holds the FSM state encoding, signed saturate/clamp helpers and default limits.
// Helpers work on a 64-bit signed carrier, so W must stay at or below 31.
package pid_mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_LATCH, S_ERR, S_DIFF, S_MP, S_MI, S_MD,
    S_SUM, S_LIMA, S_ACC, S_LIMO, S_DONE
  } state_e;

  localparam int WIDE_W = 64;
  typedef logic signed [WIDE_W-1:0] wide_t;

  localparam int DEFAULT_MAXIMUM_OUT = 1000;
  localparam int DEFAULT_MINIMUM_OUT = 0;
  localparam int DEFAULT_MAXIMUM_ADD = 100;
  localparam int DEFAULT_MINIMUM_ADD = -100;

  // Saturate v to the range of a w-bit two's-complement number.
  function automatic wide_t sat_w(input wide_t v, input int w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Clamp v into [lo, hi].
  function automatic wide_t clamp(input wide_t v, input wide_t lo, input wide_t hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/pid_mc_if.sv
// Controller-facing bundle: ADC event, samples, setpoints, gains, enables, outputs.
// Pure wiring, no latency.
// No backpressure: outputs are pulses/levels the consumer must sample.
interface pid_mc_if #(
  parameter int N_CH = 2,
  parameter int W    = 26,
  parameter int IW   = 12
);
  logic                   adc_complete;
  logic [N_CH*IW-1:0]     sample;
  logic [N_CH*W-1:0]      target;
  logic signed [W-1:0]    kp;
  logic signed [W-1:0]    ki;
  logic signed [W-1:0]    kd;
  logic [N_CH-1:0]        ch_enable;
  logic [N_CH*W-1:0]      pi_out;
  logic                   out_valid;
  logic                   busy;
  logic                   overrun;

  modport master (
    output adc_complete, sample, target, kp, ki, kd, ch_enable,
    input  pi_out, out_valid, busy, overrun
  );

  modport slave (
    input  adc_complete, sample, target, kp, ki, kd, ch_enable,
    output pi_out, out_valid, busy, overrun
  );
endinterface

// File: rtl/pid_mc_mac.sv
// Shared multiplier with registered product, three-term accumulate, shift and saturate.
// Product appears one cycle after mul_en; sum_sat is valid in the cycle after the third product.
// No backpressure: sequencing is entirely owned by the controller FSM.
module pid_mc_mac
  import pid_mc_pkg::*;
#(
  parameter int W         = 26,
  parameter int FRAC_BITS = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mul_en,
  input  logic                sum_load,
  input  logic                sum_add,
  input  logic signed [W-1:0] op_a,
  input  logic signed [W-1:0] op_b,
  output logic signed [W-1:0] sum_sat
);
  localparam int PW = 2 * W;
  localparam int SW = 2 * W + 2;

  logic signed [PW-1:0] prod_q, prod_d;
  logic signed [SW-1:0] sum_q, sum_d;
  logic signed [SW-1:0] total;
  wide_t                sat_full;
  logic                 unused_hi;

  // Product capture and partial-sum accumulation (pp, then pp+pi).
  always_comb begin
    prod_d = prod_q;
    sum_d  = sum_q;
    if (mul_en)   prod_d = PW'(op_a) * PW'(op_b);
    if (sum_load) sum_d  = SW'(prod_q);
    else if (sum_add) sum_d = sum_q + SW'(prod_q);
  end

  // The last term (pd) is still in the product register, so it is folded in here.
  assign total     = (sum_q + SW'(prod_q)) >>> FRAC_BITS;
  assign sat_full  = sat_w(wide_t'(total), W);
  assign sum_sat   = sat_full[W-1:0];
  assign unused_hi = ^sat_full[WIDE_W-1:W];

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      sum_q  <= '0;
    end else begin
      prod_q <= prod_d;
      sum_q  <= sum_d;
    end
  end
endmodule

// File: rtl/pid_mc.sv
// N-channel time-multiplexed incremental PID: one ADC event runs every channel through one MAC.
// out_valid pulses 9*N_CH+3 clocks after the synchronised ADC edge; all outputs update together.
// No backpressure: an ADC edge while busy (including DONE) is dropped and flagged on overrun.
module pid_mc
  import pid_mc_pkg::*;
#(
  parameter int N_CH                = 2,
  parameter int PARAMETER_BIT_WIDTH = 26,
  parameter int INPUT_BIT_WIDTH     = 12,
  parameter int FRAC_BITS           = 0,
  parameter int MAXIMUM_OUT         = DEFAULT_MAXIMUM_OUT,
  parameter int MINIMUM_OUT         = DEFAULT_MINIMUM_OUT,
  parameter int MAXIMUM_ADD         = DEFAULT_MAXIMUM_ADD,
  parameter int MINIMUM_ADD         = DEFAULT_MINIMUM_ADD
) (
  input logic     clk,
  input logic     rst_n,
  pid_mc_if.slave bus
);
  localparam int W    = PARAMETER_BIT_WIDTH;
  localparam int IW   = INPUT_BIT_WIDTH;
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic                dly1_q, dly1_d, dly2_q, dly2_d;
  logic [IW-1:0]       samp_q [N_CH], samp_d [N_CH];
  logic signed [W-1:0] tgt_q  [N_CH], tgt_d  [N_CH];
  logic signed [W-1:0] acc_q  [N_CH], acc_d  [N_CH];
  logic signed [W-1:0] e1_q   [N_CH], e1_d   [N_CH];
  logic signed [W-1:0] e2_q   [N_CH], e2_d   [N_CH];
  logic signed [W-1:0] kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
  logic [N_CH-1:0]     en_q, en_d;
  logic signed [W-1:0] e0_q, e0_d, d1_q, d1_d, d2_q, d2_d, s_q, s_d;
  logic signed [W:0]   acc_sum_q, acc_sum_d;
  logic [N_CH*W-1:0]   pi_out_q, pi_out_d;
  logic                out_valid_q, out_valid_d, busy_q, busy_d, overrun_q, overrun_d;

  logic                adc_read_flag;
  logic                mul_en, sum_load, sum_add;
  logic signed [W-1:0] mac_a, mac_b, mac_s;
  wide_t               lima_w, limo_w;
  logic                unused_hi;

  assign adc_read_flag = dly1_q & ~dly2_q;
  assign mul_en   = (state_q == S_MP) || (state_q == S_MI) || (state_q == S_MD);
  assign sum_load = (state_q == S_MI);
  assign sum_add  = (state_q == S_MD);
  assign lima_w   = clamp(wide_t'(s_q), wide_t'(MINIMUM_ADD), wide_t'(MAXIMUM_ADD));
  assign limo_w   = clamp(wide_t'(acc_sum_q), wide_t'(MINIMUM_OUT), wide_t'(MAXIMUM_OUT));
  assign unused_hi = ^{lima_w[WIDE_W-1:W], limo_w[WIDE_W-1:W]};

  // Steer the shared multiplier: kp*d1, ki*e0, kd*d2 on consecutive cycles.
  always_comb begin
    mac_a = kp_q;
    mac_b = d1_q;
    if (state_q == S_MI) begin
      mac_a = ki_q;
      mac_b = e0_q;
    end else if (state_q == S_MD) begin
      mac_a = kd_q;
      mac_b = d2_q;
    end
  end

  pid_mc_mac #(.W(W), .FRAC_BITS(FRAC_BITS)) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .mul_en   (mul_en),
    .sum_load (sum_load),
    .sum_add  (sum_add),
    .op_a     (mac_a),
    .op_b     (mac_b),
    .sum_sat  (mac_s)
  );

  // Sequencer and per-channel datapath next-state.
  always_comb begin
    state_d = state_q;  ch_d = ch_q;
    dly1_d = bus.adc_complete;  dly2_d = dly1_q;
    samp_d = samp_q;  tgt_d = tgt_q;  acc_d = acc_q;  e1_d = e1_q;  e2_d = e2_q;
    kp_d = kp_q;  ki_d = ki_q;  kd_d = kd_q;  en_d = en_q;
    e0_d = e0_q;  d1_d = d1_q;  d2_d = d2_q;  s_d = s_q;  acc_sum_d = acc_sum_q;
    pi_out_d = pi_out_q;  out_valid_d = 1'b0;
    // Any new event outside IDLE is lost; DONE still counts as busy.
    overrun_d = adc_read_flag && (state_q != S_IDLE);
    case (state_q)
      S_IDLE:  if (adc_read_flag) state_d = S_LATCH;
      S_LATCH: begin
        for (int c = 0; c < N_CH; c++) begin
          samp_d[c] = bus.sample[c*IW +: IW];
          tgt_d[c]  = $signed(bus.target[c*W +: W]);
        end
        kp_d = bus.kp;  ki_d = bus.ki;  kd_d = bus.kd;  en_d = bus.ch_enable;
        ch_d = '0;
        state_d = S_ERR;
      end
      S_ERR: begin
        e0_d = tgt_q[ch_q] - $signed({{(W-IW){1'b0}}, samp_q[ch_q]});
        state_d = S_DIFF;
      end
      S_DIFF: begin
        d1_d = e0_q - e1_q[ch_q];
        d2_d = e0_q - (e1_q[ch_q] <<< 1) + e2_q[ch_q];
        state_d = S_MP;
      end
      S_MP:  state_d = S_MI;
      S_MI:  state_d = S_MD;
      S_MD:  state_d = S_SUM;
      S_SUM: begin
        s_d = mac_s;
        state_d = S_LIMA;
      end
      S_LIMA: begin
        s_d = lima_w[W-1:0];
        state_d = S_ACC;
      end
      S_ACC: begin
        acc_sum_d = $signed({acc_q[ch_q][W-1], acc_q[ch_q]}) + $signed({s_q[W-1], s_q});
        state_d = S_LIMO;
      end
      S_LIMO: begin
        // Disabled channels burn the same cycles but keep their state frozen.
        if (en_q[ch_q]) begin
          acc_d[ch_q] = limo_w[W-1:0];
          e2_d[ch_q]  = e1_q[ch_q];
          e1_d[ch_q]  = e0_q;
        end
        if (ch_q == CH_W'(N_CH - 1)) begin
          state_d = S_DONE;
        end else begin
          ch_d = ch_q + CH_W'(1);
          state_d = S_ERR;
        end
      end
      S_DONE: begin
        for (int c = 0; c < N_CH; c++) pi_out_d[c*W +: W] = acc_q[c];
        out_valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // All controller state; reset abandons any pass in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;  ch_q <= '0;  dly1_q <= 1'b0;  dly2_q <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        samp_q[c] <= '0;  tgt_q[c] <= '0;  acc_q[c] <= '0;  e1_q[c] <= '0;  e2_q[c] <= '0;
      end
      kp_q <= '0;  ki_q <= '0;  kd_q <= '0;  en_q <= '0;
      e0_q <= '0;  d1_q <= '0;  d2_q <= '0;  s_q <= '0;  acc_sum_q <= '0;
      pi_out_q <= '0;  out_valid_q <= 1'b0;  busy_q <= 1'b0;  overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;  ch_q <= ch_d;  dly1_q <= dly1_d;  dly2_q <= dly2_d;
      samp_q <= samp_d;  tgt_q <= tgt_d;  acc_q <= acc_d;  e1_q <= e1_d;  e2_q <= e2_d;
      kp_q <= kp_d;  ki_q <= ki_d;  kd_q <= kd_d;  en_q <= en_d;
      e0_q <= e0_d;  d1_q <= d1_d;  d2_q <= d2_d;  s_q <= s_d;  acc_sum_q <= acc_sum_d;
      pi_out_q <= pi_out_d;  out_valid_q <= out_valid_d;  busy_q <= busy_d;  overrun_q <= overrun_d;
    end
  end

  assign bus.pi_out    = pi_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_pid_mc.sv
// Bench for pid_mc: scoreboard of expected channel outputs, pushed per ADC edge, popped on out_valid.
// dut0 runs with FRAC_BITS=0 against a reference model; dut1 runs with FRAC_BITS=4.
// Covers latency, clamps, disable, overrun (mid-pass and in DONE), mid-pass reset.
module tb_pid_mc;
  localparam int N  = 2;
  localparam int W  = 26;
  localparam int IW = 12;

  typedef struct packed { longint c1; longint c0; } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;
  exp_t q0[$];
  exp_t q1[$];

  // Reference model state for dut0.
  longint              m_e1[N], m_e2[N], m_acc[N];
  logic signed [W-1:0] tgt[N];
  int                  smp[N];
  longint              kp_v, ki_v, kd_v;
  logic [N-1:0]        en_v;

  pid_mc_if #(.N_CH(N), .W(W), .IW(IW)) bus0();
  pid_mc_if #(.N_CH(N), .W(W), .IW(IW)) bus1();

  pid_mc #(.N_CH(N), .PARAMETER_BIT_WIDTH(W), .INPUT_BIT_WIDTH(IW), .FRAC_BITS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  pid_mc #(.N_CH(N), .PARAMETER_BIT_WIDTH(W), .INPUT_BIT_WIDTH(IW), .FRAC_BITS(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint lim(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic apply_inputs();
    bus0.sample    = {IW'(smp[1]), IW'(smp[0])};
    bus0.target    = {tgt[1], tgt[0]};
    bus0.kp        = W'(kp_v);
    bus0.ki        = W'(ki_v);
    bus0.kd        = W'(kd_v);
    bus0.ch_enable = en_v;
  endtask

  // Incremental PID per enabled channel, from the inputs present at the edge.
  task automatic model_step();
    exp_t   e;
    longint e0, d1, d2, s;
    for (int c = 0; c < N; c++) begin
      if (en_v[c]) begin
        e0 = longint'(tgt[c]) - longint'(smp[c]);
        d1 = e0 - m_e1[c];
        d2 = e0 - 2 * m_e1[c] + m_e2[c];
        s  = lim(kp_v * d1 + ki_v * e0 + kd_v * d2, -100, 100);
        m_acc[c] = lim(m_acc[c] + s, 0, 1000);
        m_e2[c]  = m_e1[c];
        m_e1[c]  = e0;
      end
    end
    e.c0 = m_acc[0];
    e.c1 = m_acc[1];
    q0.push_back(e);
  endtask

  // One ADC edge on dut0; latency measured from the clock that first sees the edge.
  task automatic fire();
    int n;
    bit seen;
    apply_inputs();
    model_step();
    @(negedge clk) bus0.adc_complete = 1'b1;
    @(posedge clk);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      seen = bus0.out_valid;
    end
    chk("latency", n, 21);
    bus0.adc_complete = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Two ADC edges 'gap' clocks apart; the second must be dropped with one overrun pulse.
  task automatic double_edge(input int gap);
    int ov, vd;
    apply_inputs();
    model_step();
    ov = 0;
    vd = 0;
    @(negedge clk) bus0.adc_complete = 1'b1;
    for (int i = 1; i < 60; i++) begin
      @(negedge clk);
      if (bus0.overrun) ov++;
      if (bus0.out_valid) vd++;
      if (i == 1) bus0.adc_complete = 1'b0;
      if (i == gap) bus0.adc_complete = 1'b1;
      if (i == 8) begin
        bus0.ki = W'(-50);
        bus0.target[W-1:0] = W'(900);
      end
      if (i == 10) chk("busy_mid", bus0.busy, 1);
    end
    chk("overrun_pulses", ov, 1);
    chk("valid_pulses", vd, 1);
    bus0.adc_complete = 1'b0;
    apply_inputs();
    repeat (3) @(negedge clk);
  endtask

  // Scoreboard for dut0.
  always @(negedge clk) begin
    exp_t e;
    if (bus0.out_valid === 1'b1) begin
      chk("dut0_pending", q0.size() > 0, 1);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("dut0_ch0", longint'($signed(bus0.pi_out[W-1:0])), e.c0);
        chk("dut0_ch1", longint'($signed(bus0.pi_out[2*W-1:W])), e.c1);
      end
    end
  end

  // Scoreboard for dut1.
  always @(negedge clk) begin
    exp_t e;
    if (bus1.out_valid === 1'b1) begin
      chk("dut1_pending", q1.size() > 0, 1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("dut1_ch0", longint'($signed(bus1.pi_out[W-1:0])), e.c0);
        chk("dut1_ch1", longint'($signed(bus1.pi_out[2*W-1:W])), e.c1);
      end
    end
  end

  initial begin
    exp_t e;
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    kp_v = 10; ki_v = 1; kd_v = 0; en_v = 2'b11;
    tgt[0] = W'(500); tgt[1] = '0; smp[0] = 400; smp[1] = 0;
    for (int c = 0; c < N; c++) begin m_e1[c] = 0; m_e2[c] = 0; m_acc[c] = 0; end
    bus0.adc_complete = 1'b0;
    apply_inputs();
    bus1.adc_complete = 1'b0; bus1.sample = '0; bus1.target = '0;
    bus1.kp = '0; bus1.ki = '0; bus1.kd = '0; bus1.ch_enable = 2'b11;

    repeat (3) @(negedge clk);
    chk("rst_pi_out", bus0.pi_out, 0);
    chk("rst_out_valid", bus0.out_valid, 0);
    chk("rst_busy", bus0.busy, 0);
    chk("rst_overrun", bus0.overrun, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    fire();                       // first step: 1100 clamped to 100
    fire();                       // steady error: 200
    smp[0] = 550;
    fire();                       // reversal: -1550 clamped to -100
    smp[0] = 400;
    repeat (10) fire();           // climbs and pins at 1000

    en_v = 2'b01; tgt[1] = W'(300);
    fire();
    fire();                       // ch1 frozen at 0
    en_v = 2'b11; tgt[1] = '0;

    double_edge(5);               // edge mid-pass, gains/target poked mid-pass
    double_edge(20);              // edge lands in DONE

    // Reset while channel 0 is in MD.
    tgt[1] = W'(7); smp[1] = 2;
    apply_inputs();
    @(negedge clk) bus0.adc_complete = 1'b1;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_pi_out", bus0.pi_out, 0);
    chk("midrst_out_valid", bus0.out_valid, 0);
    chk("midrst_busy", bus0.busy, 0);
    chk("midrst_overrun", bus0.overrun, 0);
    bus0.adc_complete = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < N; c++) begin m_e1[c] = 0; m_e2[c] = 0; m_acc[c] = 0; end
    repeat (2) @(negedge clk);
    fire();                       // behaves as first sample: ch0 100, ch1 55

    // Fractional gains on dut1: (16*3 + 32*3) >>> 4 = 9.
    bus1.kp = '0; bus1.ki = W'(16); bus1.kd = W'(32);
    bus1.target = {W'(0), W'(3)};
    bus1.sample = '0;
    e.c0 = 9;
    e.c1 = 0;
    q1.push_back(e);
    @(negedge clk) bus1.adc_complete = 1'b1;
    repeat (30) @(negedge clk);
    bus1.adc_complete = 1'b0;

    chk("dut0_drained", q0.size(), 0);
    chk("dut1_drained", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
